// File: rtl/rf_pkg.sv
// Shared register-file definitions: default geometry and the write-arbiter FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   RF_ADDR_W / RF_DATA_W / RF_DEPTH : default register file geometry
//   rf_state_e                       : write-port owner, INIT = clear sweep, RUN = requesters
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

  // INIT owns the write port until every entry has been cleared once,
  // then RUN hands it to the requesters for the rest of time.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

endpackage : rf_pkg

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr (wrapping) wins.
// Latency: purely combinational, grant follows valid/ptr in the same cycle.
// Backpressure: none here; the caller decides when the grant is allowed out.
//
// Ports:
//   valid [NUM_REQ-1:0] : request vector
//   ptr   [PTR_W-1:0]   : highest-priority index, must be < NUM_REQ
//   grant [NUM_REQ-1:0] : one-hot (or zero when nothing is valid)
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [PTR_W:0] NUM_L = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requesters in priority order starting at ptr; the first valid
  // one seen gets the grant and every later candidate is masked by 'found'.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (pos >= NUM_L) begin
        pos = pos - NUM_L;
      end
      idx = pos[PTR_W-1:0];
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: clears every entry after reset, then round-robins NUM_REQ writers onto one port.
// Latency: a handshake in cycle N appears on the write port in cycle N+1 (registered outputs).
// Backpressure: ready is held low during the clear sweep; afterwards at most one requester is ready per cycle.
//
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   req_valid_i/_addr_i/_data_i: per-requester write requests, requester k at slice k
//   req_ready_o               : per-requester accept (handshake = valid & ready)
//   rf_we_o/_waddr_o/_wdata_o : register file write port
//   init_done_o               : high from the first cycle after the clear sweep has been written out
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      rf_we_o,
  output logic [ADDR_W-1:0]         rf_waddr_o,
  output logic [DATA_W-1:0]         rf_wdata_o,
  output logic                      init_done_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // The sweep counter is one bit wider than an address so that reaching
  // 2**ADDR_W means "last clear write is already on the port".
  localparam logic [ADDR_W:0]  SWEEP_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  rf_state_e           state;
  logic [ADDR_W:0]     sweep_cnt;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_nxt;
  logic [PTR_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  hs;
  logic                hs_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .valid (req_valid_i),
    .ptr   (ptr),
    .grant (grant)
  );

  // Requesters are locked out while the sweep owns the port. state is reset
  // asynchronously to INIT, so ready drops the moment rst_ni falls.
  assign req_ready_o = (state == RUN) ? grant : '0;
  assign hs          = req_valid_i & req_ready_o;
  assign hs_any      = |hs;

  // hs is one-hot, so this loop just encodes the winner and picks its
  // address/data slice; these are captured only on the handshake edge.
  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hs[k]) begin
        gnt_idx  = PTR_W'(k);
        sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Priority moves to the requester just after the winner, wrapping.
  assign ptr_nxt = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= INIT;
      sweep_cnt   <= '0;
      ptr         <= '0;
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      init_done_o <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (sweep_cnt == SWEEP_END) begin
            // Last clear write went out on the previous edge; hand over.
            state       <= RUN;
            init_done_o <= 1'b1;
            rf_we_o     <= 1'b0;
          end else begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= sweep_cnt[ADDR_W-1:0];
            rf_wdata_o <= '0;
            sweep_cnt  <= sweep_cnt + (ADDR_W + 1)'(1);
          end
        end

        RUN: begin
          rf_we_o <= 1'b0;
          if (hs_any) begin
            ptr <= ptr_nxt;
            // Register 0 is hard-wired to zero: the request is consumed
            // but never reaches the port, and the port keeps its last value.
            if (sel_addr != '0) begin
              rf_we_o    <= 1'b1;
              rf_waddr_o <= sel_addr;
              rf_wdata_o <= sel_data;
            end
          end
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Structural guarantees the rest of the pipeline relies on.
  a_ready_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_ready_only_in_run : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state != RUN) |-> (req_ready_o == '0));

  a_ready_only_to_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((req_ready_o & ~req_valid_i) == '0));

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int N  = 3;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;

  logic              clk_i  = 1'b0;
  logic              rst_ni = 1'b1;
  logic [N-1:0]      req_valid_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_ready_o;
  logic              rf_we_o;
  logic [AW-1:0]     rf_waddr_o;
  logic [DW-1:0]     rf_wdata_o;
  logic              init_done_o;

  rf_write_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .init_done_o (init_done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[k]          = v;
    req_addr_i[k*AW +: AW]  = a;
    req_data_i[k*DW +: DW]  = d;
  endtask

  // Called at posedge+2 with inputs set; checks ready against the hand
  // value, queues the expected write for the next edge, advances one cycle.
  task automatic step(input logic [N-1:0] exp_rdy, input string name);
    exp_t e;
    #1;
    chk(name, req_ready_o, exp_rdy);
    for (int k = 0; k < N; k++) begin
      if (exp_rdy[k] && req_valid_i[k] && (req_addr_i[k*AW +: AW] != '0)) begin
        e.due  = cyc + 1;
        e.addr = req_addr_i[k*AW +: AW];
        e.data = req_data_i[k*DW +: DW];
        sb.push_back(e);
      end
    end
    @(posedge clk_i);
    #2;
  endtask

  task automatic release_and_sweep(input int nsteps);
    exp_t e;
    rst_ni = 1'b1;
    for (int i = 0; i < RF_DEPTH; i++) begin
      e.due  = cyc + 1 + i;
      e.addr = AW'(i);
      e.data = '0;
      sb.push_back(e);
    end
    for (int i = 0; i < nsteps; i++) begin
      chk("init_done_low", init_done_o, 1'b0);
      step('0, "sweep_ready");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    rf_we_o,     1'b0);
    chk({tag, "_waddr"}, rf_waddr_o,  '0);
    chk({tag, "_wdata"}, rf_wdata_o,  '0);
    chk({tag, "_done"},  init_done_o, 1'b0);
    chk({tag, "_ready"}, req_ready_o, '0);
  endtask

  // Monitor: every write on the port must match the head of the scoreboard,
  // including the cycle it was due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rf_we_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=0x%0h data=0x%0h with empty scoreboard (cycle %0d)",
                   rf_waddr_o, rf_wdata_o, cyc);
        end else begin
          e = sb.pop_front();
          chk("wr_cycle", cyc,        e.due);
          chk("wr_addr",  rf_waddr_o, e.addr);
          chk("wr_data",  rf_wdata_o, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid_i = '0;
    req_addr_i  = '0;
    req_data_i  = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    set_req(2, 1'b1, 5'd3, 32'h3);
    #1;
    chk("rst_ready_with_valid", req_ready_o, '0);
    repeat (2) @(posedge clk_i);
    #2;
    chk_reset_outputs("rst_held");
    req_valid_i = '0;

    // Clear sweep with no requests: 32 writes then init_done.
    release_and_sweep(RF_DEPTH + 1);
    chk("init_done_high", init_done_o, 1'b1);
    chk("first_run_we", rf_we_o, 1'b0);

    // All three valid: grants rotate 0,1,2,0,1,2.
    set_req(0, 1'b1, 5'd1, 32'hAAAA_0001);
    set_req(1, 1'b1, 5'd2, 32'hBBBB_0002);
    set_req(2, 1'b1, 5'd3, 32'hCCCC_0003);
    step(3'b001, "rr_a0");
    step(3'b010, "rr_a1");
    step(3'b100, "rr_a2");
    step(3'b001, "rr_b0");
    step(3'b010, "rr_b1");
    step(3'b100, "rr_b2");
    req_valid_i = '0;
    step(3'b000, "idle_after_rr");
    chk("hold_we",    rf_we_o,    1'b0);
    chk("hold_waddr", rf_waddr_o, 5'd3);
    chk("hold_wdata", rf_wdata_o, 32'hCCCC_0003);

    // Write to register 0 is accepted but suppressed.
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(3'b010, "addr0_ready");
    chk("addr0_we", rf_we_o, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    step(3'b000, "idle_after_addr0");

    // Requester 2 alone for four cycles (ptr starts at 2, wraps to 0 each time).
    for (int i = 0; i < 4; i++) begin
      set_req(2, 1'b1, AW'(4 + i), 32'h2222_0000 + i);
      step(3'b100, "solo_r2");
    end
    set_req(2, 1'b0, 5'd0, 32'h0);

    // Pointer sequence with requesters 0 and 1: ptr 0 -> 1 -> 2 -> grant 0.
    set_req(0, 1'b1, 5'd8, 32'h0808_0808);
    set_req(1, 1'b1, 5'd9, 32'h0909_0909);
    step(3'b001, "pair_p0");
    step(3'b010, "pair_p1");
    step(3'b001, "pair_p2_wrap");
    req_valid_i = '0;

    // Payload sampled only at the handshake; a change forms a new request.
    set_req(0, 1'b1, 5'd10, 32'h1010_1010);
    step(3'b001, "sample_first");
    set_req(0, 1'b1, 5'd11, 32'h1111_1111);
    step(3'b001, "sample_second");
    req_valid_i = '0;
    step(3'b000, "idle_after_sample");
    chk("hold2_waddr", rf_waddr_o, 5'd11);
    chk("hold2_wdata", rf_wdata_o, 32'h1111_1111);

    // Reset, then interrupt the sweep at address 17 with valids held high.
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rst_run");
    sb.delete();
    @(posedge clk_i);
    #2;
    req_valid_i = '1;
    release_and_sweep(18);
    chk("mid_sweep_addr", rf_waddr_o, 5'd17);
    chk("mid_sweep_we",   rf_we_o,    1'b1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_sweep");
    sb.delete();
    @(posedge clk_i);
    #2;
    release_and_sweep(RF_DEPTH + 1);
    chk("init_done_after_restart", init_done_o, 1'b1);

    // ptr was 1 before reset; after reset it must start at 0 again.
    set_req(0, 1'b1, 5'd20, 32'h2020_2020);
    set_req(1, 1'b1, 5'd21, 32'h2121_2121);
    set_req(2, 1'b1, 5'd22, 32'h2222_2222);
    step(3'b001, "ptr_after_reset");
    req_valid_i = '0;
    step(3'b000, "final_idle");
    step(3'b000, "final_idle2");

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rf_write_arbiter

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of write requesters (2..8).
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  NUM_REQ  per-requester write request.
REQ-007 req_addr_i  input  NUM_REQ*ADDR_W  packed write addresses, requester k at bits [k*ADDR_W +: ADDR_W].
REQ-008 req_data_i  input  NUM_REQ*DATA_W  packed write data, same packing.
REQ-009 req_ready_o  output  NUM_REQ  per-requester accept; handshake = valid & ready.
REQ-010 rf_we_o  output  1  write enable to register file write port.
REQ-011 rf_waddr_o  output  ADDR_W  write address to register file.
REQ-012 rf_wdata_o  output  DATA_W  write data to register file.
REQ-013 init_done_o  output  1  high once post-reset clear sweep is complete.

Function
REQ-014 FSM states INIT and RUN; INIT entered on reset, RUN entered after sweep, no other transitions.
REQ-015 INIT: one write per cycle, rf_we_o=1, rf_wdata_o=0, rf_waddr_o counting 0..2**ADDR_W-1; final address moves FSM to RUN next cycle.
REQ-016 INIT lasts exactly 2**ADDR_W cycles after reset release (32 by default); init_done_o rises on the first RUN cycle.
REQ-017 In INIT all req_ready_o SHALL be 0.
REQ-018 In RUN at most one req_ready_o bit high per cycle (one-hot or zero).
REQ-019 req_ready_o is combinational from req_valid_i and the priority pointer; ready asserted only toward a valid requester.
REQ-020 Round-robin: search starts at pointer ptr, first valid index at or after ptr (mod NUM_REQ) is granted.
REQ-021 On a handshake with requester g, ptr <= (g+1) mod NUM_REQ; with no handshake ptr holds; ptr resets to 0.
REQ-022 Fairness: a requester holding valid high is granted within NUM_REQ cycles.
REQ-023 Write latency: handshake in cycle N drives rf_we_o=1 with that request's addr/data in cycle N+1 (registered outputs).
REQ-024 Handshake to address 0 is accepted (ready=1) but SHALL produce rf_we_o=0 in N+1; register 0 stays 0.
REQ-025 Cycle with no handshake in RUN: rf_we_o=0 next cycle; rf_waddr_o/rf_wdata_o hold last value.
REQ-026 Back-to-back handshakes every cycle SHALL be sustained (throughput 1 write/cycle).
REQ-027 Requester data/address SHALL be sampled only at the handshake cycle; later changes have no effect.

Reset
REQ-028 Asynchronous assertion of rst_ni clears immediately: state=INIT, sweep counter=0, ptr=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, init_done_o=0, req_ready_o=0.
REQ-029 Reset mid-sweep or mid-RUN discards any pending registered write and restarts the sweep at address 0 after release.
REQ-030 First sweep write (address 0) appears on the first rising edge after rst_ni deasserts.

Structure
REQ-031 Shared package rf_pkg holds RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32 and the FSM enum {INIT, RUN}.
REQ-032 Round-robin grant logic is a sub-module rr_arbiter (inputs valid vector, ptr; output one-hot grant); the FSM, sweep counter and output registers stay in rf_write_arbiter.

Verification
REQ-033 Reset release, no requests -> rf_we_o=1 for 32 cycles, addresses 0..31, data 0; init_done_o=1 on cycle 33; ready=0 throughout sweep.
REQ-034 RUN, all 3 valid continuously (addr 1/2/3, data A/B/C) -> grants 0,1,2,0,1,2; rf_we_o writes 1:A,2:B,3:C repeating, each one cycle after its handshake.
REQ-035 RUN, requester 1 writes addr 0 data 0xFFFF_FFFF -> ready_o[1]=1, next cycle rf_we_o=0.
REQ-036 Only requester 2 valid for 4 cycles -> 4 handshakes, 4 consecutive writes, ptr wraps to 0 each time.
REQ-037 rst_ni asserted at sweep address 17 for one cycle -> outputs zero immediately; after release sweep restarts at 0, init_done_o after 32 more cycles.
REQ-038 Requester changes addr/data after handshake while valid stays high -> written values match handshake-cycle sample, new values form a fresh request.
